sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data word width in bits (1..64).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning entry count (a power of two, 2..1024).
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, meaning the count at or above which almost_full asserts.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, meaning the count at or below which almost_empty asserts.
REQ-005 The block SHALL have parameter FWFT, default 0, meaning read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-008 The block SHALL have port clr, input, 1 bit, a synchronous flush.
REQ-009 The block SHALL have port w_en, input, 1 bit, the write request.
REQ-010 The block SHALL have port data_in, input, DATA_W bits, the write data.
REQ-011 The block SHALL have port r_en, input, 1 bit, the read request.
REQ-012 The block SHALL have port data_out, output, DATA_W bits, the read data.
REQ-013 The block SHALL have ports full and empty, output, 1 bit each, the occupancy flags.
REQ-014 The block SHALL have ports almost_full and almost_empty, output, 1 bit each, the threshold flags.
REQ-015 The block SHALL have port count, output, $clog2(DEPTH)+1 bits, the current occupancy (0..DEPTH).
REQ-016 The block SHALL have ports overflow and underflow, output, 1 bit each, the sticky error flags.

Function
REQ-017 A write SHALL be accepted iff w_en=1 and full=0 at the clock edge; the accepted word SHALL be stored at the write pointer, and the pointer SHALL advance by one modulo DEPTH.
REQ-018 A read SHALL be accepted iff r_en=1 and empty=0 at the clock edge; the read pointer SHALL advance by one modulo DEPTH.
REQ-019 An accepted write alone SHALL increment count; an accepted read alone SHALL decrement it; a simultaneous accepted write and read SHALL leave count unchanged.
REQ-020 With FWFT=1 and both w_en and r_en asserted while full: the read SHALL be accepted, the write SHALL be dropped, and overflow SHALL set.
REQ-021 With FWFT=1 and both w_en and r_en asserted while empty: the write SHALL be accepted, the read SHALL be rejected, and underflow SHALL set.
REQ-022 With FWFT=0, an accepted read SHALL load data_out with the head entry on the same edge, so data is valid 1 cycle after r_en; data_out SHALL hold its value at all other times.
REQ-023 With FWFT=1, data_out SHALL show the head entry whenever empty=0, with 0-cycle read latency; r_en SHALL act as the pop; data_out SHALL be 0 while empty.
REQ-024 The flags SHALL be registered and decoded from the next count value: full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL), almost_empty=(count<=AE_LEVEL).
REQ-025 The pointers SHALL carry one extra wrap bit; full SHALL be decided when the pointer MSBs differ and the lower bits are equal.
REQ-026 overflow SHALL set on w_en while full, and underflow SHALL set on r_en while empty; both SHALL stay set until clr or reset.
REQ-027 clr=1 SHALL zero the pointers, count and sticky flags at the next edge, SHALL set the flags to their reset values, and SHALL take priority over w_en/r_en in the same cycle.
REQ-028 Memory contents SHALL NOT be cleared by clr or by reset.

Reset
REQ-029 rst_n=0 SHALL immediately force: pointers 0, count 0, data_out 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0.
REQ-030 Reset asserted mid-transfer SHALL discard all queued data; the first read after release SHALL return only data written after release.

Structure
REQ-031 Package fifo_pkg SHALL hold the default DATA_W, DEPTH and FWFT constants and the count-width function.
REQ-032 The storage SHALL be sub-module fifo_mem: a DEPTH x DATA_W register array with a synchronous write port and an asynchronous read port.
REQ-033 Parameter legality (DEPTH a power of two, AE_LEVEL < AF_LEVEL <= DEPTH) SHALL be checked at elaboration.

Verification
REQ-034 With DEPTH=16, DATA_W=8, FWFT=0: write 0x01..0x10 -> full=1, count=16, almost_full from count 14; a 17th write -> overflow=1 and data unchanged.
REQ-035 Read 16 words -> data_out 0x01..0x10 in order, each valid 1 cycle after r_en; then empty=1 and almost_empty from count 2; a 17th read -> underflow=1.
REQ-036 At count=8, hold w_en=r_en=1 for 20 cycles -> count stays 8, order is preserved across pointer wrap, and no error flags are raised.
REQ-037 With FWFT=1: write 0xA5 into an empty FIFO -> data_out=0xA5 one cycle later without r_en; pulse r_en -> empty=1 and data_out=0.
REQ-038 Fill 5 words, assert clr together with w_en -> count=0, empty=1, sticky flags cleared, write ignored; the next write/read returns the new word.
REQ-039 Assert rst_n=0 asynchronously mid-burst -> outputs reach reset values before the next edge; after release, behaviour is as in REQ-034.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and the count-width helper for the FIFO slice.
package fifo_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_FWFT   = 0;
  // Occupancy needs one more bit than the address so that DEPTH itself is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_param_mem.sv
// fifo_mem: DEPTH x DATA_W register array, synchronous write, asynchronous read.
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read port.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // No reset on the array: contents survive both reset and flush.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised synchronous FIFO with registered or first-word-fall-through read.
// Ports: clk, rst_n (async active-low), clr (sync flush); w_en/data_in write side;
//        r_en/data_out read side; full/empty/almost_full/almost_empty flags;
//        count occupancy; overflow/underflow sticky error flags.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = DEF_FWFT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   w_en,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   r_en,
  output logic [DATA_W-1:0]      data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = cnt_w(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad
    $error("sync_fifo_param: illegal DEPTH/AE_LEVEL/AF_LEVEL");
  end

  logic [PW-1:0]     wp, rp, wp_n, rp_n;
  logic [CW-1:0]     count_n;
  logic [DATA_W-1:0] head;
  logic              wr_ok, rd_ok;

  // Flush wins over both requests, so it also gates the memory write.
  always_comb begin
    wr_ok   = w_en && !full && !clr;
    rd_ok   = r_en && !empty && !clr;
    wp_n    = clr ? '0 : wp + PW'(wr_ok);
    rp_n    = clr ? '0 : rp + PW'(rd_ok);
    count_n = clr ? '0 : count + CW'(wr_ok) - CW'(rd_ok);
  end

  // Flags are registered from the next-state values so they line up with count.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp           <= '0;
      rp           <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wp           <= wp_n;
      rp           <= rp_n;
      count        <= count_n;
      full         <= (wp_n[AW] != rp_n[AW]) && (wp_n[AW-1:0] == rp_n[AW-1:0]);
      empty        <= count_n == '0;
      almost_full  <= count_n >= CW'(AF_LEVEL);
      almost_empty <= count_n <= CW'(AE_LEVEL);
      overflow     <= !clr && (overflow || (w_en && full));
      underflow    <= !clr && (underflow || (r_en && empty));
    end

  fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wp[AW-1:0]),
    .wdata (data_in),
    .raddr (rp[AW-1:0]),
    .rdata (head)
  );

  if (FWFT != 0) begin : g_fwft
    assign data_out = empty ? '0 : head;
  end else begin : g_reg
    logic [DATA_W-1:0] dq;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) dq <= '0;
      else if (rd_ok) dq <= head;
    assign data_out = dq;
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed scoreboard bench for registered-read and FWFT FIFO instances.
module tb_sync_fifo_param;
  logic       clk = 0, rst_n = 1;
  logic       clr = 0, w_en = 0, r_en = 0;
  logic [7:0] data_in = 0, data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  logic       c1 = 0, w1 = 0, r1 = 0;
  logic [7:0] d1 = 0, q1;
  logic       f1, e1, af1, ae1, o1, u1f;
  logic [4:0] n1;
  int total = 0, bad = 0;
  logic [7:0] q[$];
  logic [7:0] exp_d = 0;
  logic       m_ovf = 0, m_unf = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow));

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .clr(c1), .w_en(w1), .data_in(d1), .r_en(r1),
    .data_out(q1), .full(f1), .empty(e1), .almost_full(af1),
    .almost_empty(ae1), .count(n1), .overflow(o1), .underflow(u1f));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".full"}, 32'(full), 32'(n == 16));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".af"}, 32'(almost_full), 32'(n >= 14));
    chk({tag, ".ae"}, 32'(almost_empty), 32'(n <= 2));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    chk({tag, ".dout"}, 32'(data_out), 32'(exp_d));
  endtask

  // One clock on the registered-read instance with scoreboard update and full check.
  task automatic cyc(input string tag, input logic w, input logic [7:0] d, input logic r, input logic c);
    logic wa, ra;
    wa = w && q.size() < 16 && !c;
    ra = r && q.size() > 0 && !c;
    w_en = w; data_in = d; r_en = r; clr = c;
    @(posedge clk); #1;
    if (c) begin
      q.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      if (w && !wa) m_ovf = 1;
      if (r && !ra) m_unf = 1;
      if (ra) exp_d = q.pop_front();
      if (wa) q.push_back(d);
    end
    w_en = 0; r_en = 0; clr = 0;
    chk_all(tag);
  endtask

  task automatic chk_reset(input string tag);
    q.delete(); exp_d = 0; m_ovf = 0; m_unf = 0;
    chk_all(tag);
  endtask

  task automatic tick1();
    @(posedge clk); #1;
    w1 = 0; r1 = 0; c1 = 0;
  endtask

  initial begin
    #2 rst_n = 0;
    #1 chk_reset("reset");
    @(negedge clk); @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    // Fill to full, then overflow.
    for (int i = 1; i <= 16; i++) cyc("fill", 1, 8'(i), 0, 0);
    cyc("wr17", 1, 8'hEE, 0, 0);
    // Drain in order, then underflow.
    for (int i = 1; i <= 16; i++) cyc("drain", 0, 0, 1, 0);
    chk("last_word", 32'(data_out), 32'h10);
    cyc("rd17", 0, 0, 1, 0);
    cyc("clr_flags", 0, 0, 0, 1);
    // Steady state at count 8 across pointer wrap.
    for (int i = 0; i < 8; i++) cyc("half", 1, 8'(8'h40 + i), 0, 0);
    for (int i = 0; i < 20; i++) cyc("both", 1, 8'(8'h60 + i), 1, 0);
    // Flush with a coincident write.
    cyc("pre_clr", 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc("five", 1, 8'(8'h70 + i), 0, 0);
    cyc("clr_w", 1, 8'h77, 0, 1);
    cyc("post_w", 1, 8'h99, 0, 0);
    cyc("post_r", 0, 0, 1, 0);
    chk("post_clr_word", 32'(data_out), 32'h99);
    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 4; i++) cyc("burst", 1, 8'(8'hB0 + i), 0, 0);
    w_en = 1; data_in = 8'hBF;
    @(posedge clk); #3 rst_n = 0;
    #1 chk_reset("async_rst");
    w_en = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    chk_all("after_rel");
    for (int i = 0; i < 3; i++) cyc("rel_w", 1, 8'(8'hC0 + i), 0, 0);
    for (int i = 0; i < 3; i++) cyc("rel_r", 0, 0, 1, 0);
    // First-word-fall-through instance.
    chk("f.empty0", 32'(e1), 32'd1);
    chk("f.dout0", 32'(q1), 32'd0);
    w1 = 1; d1 = 8'hA5; tick1();
    chk("f.dout_a5", 32'(q1), 32'hA5);
    chk("f.empty_a5", 32'(e1), 32'd0);
    r1 = 1; tick1();
    chk("f.empty_pop", 32'(e1), 32'd1);
    chk("f.dout_pop", 32'(q1), 32'd0);
    w1 = 1; r1 = 1; d1 = 8'h3C; tick1();
    chk("f.both_empty.count", 32'(n1), 32'd1);
    chk("f.both_empty.unf", 32'(u1f), 32'd1);
    chk("f.both_empty.dout", 32'(q1), 32'h3C);
    for (int i = 1; i < 16; i++) begin
      w1 = 1; d1 = 8'(8'hD0 + i); tick1();
    end
    chk("f.full", 32'(f1), 32'd1);
    w1 = 1; r1 = 1; d1 = 8'hFF; tick1();
    chk("f.both_full.count", 32'(n1), 32'd15);
    chk("f.both_full.ovf", 32'(o1), 32'd1);
    chk("f.both_full.dout", 32'(q1), 32'hD1);
    c1 = 1; tick1();
    chk("f.clr.count", 32'(n1), 32'd0);
    chk("f.clr.flags", 32'({o1, u1f, e1, ae1, f1, af1}), 32'b001100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
